riscvibe_dmem_responder: RTL

Data-memory responder for the RV32I pipeline: the target end of the MEM-stage load/store request. It accepts one request at a time over a valid/ready handshake and performs little-endian byte, halfword or word accesses on an internal word array. It returns sign- or zero-extended load data, or a store acknowledge, a fixed number of cycles later. Misaligned, out-of-range and illegal-width requests are flagged with an error and have no side effects.

---
 rtl/riscvibe_dmem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/riscvibe_dmem_responder.sv
// Data-memory responder for the RV32I MEM stage: one request at a time,
// little-endian B/H/W access on a word array, fixed-latency response.
module riscvibe_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [2:0]    cap_width;
    logic [31:0]   cap_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          s_we;
    logic [31:0]   s_addr;
    logic [2:0]    s_width;
    logic [31:0]   s_wdata;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          bad_w, mis, oor, err;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ld_data;
    logic [31:0]   rdata_nx;
    logic [3:0]    be;
    logic [31:0]   wword;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY == 1 the array is accessed on the accept edge itself,
    // before the capture registers hold the request.
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == '0));

    assign s_we    = (state == IDLE) ? req_we    : cap_we;
    assign s_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign s_width = (state == IDLE) ? req_width : cap_width;
    assign s_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    assign idx  = s_addr[AW+1:2];
    assign lane = s_addr[1:0];
    assign oor  = |s_addr[31:AW+2];
    assign err  = bad_w | mis | oor;

    always_comb begin
        bad_w = 1'b1;
        mis   = 1'b0;
        case (s_width)
            3'b000: bad_w = 1'b0;
            3'b001: begin
                bad_w = 1'b0;
                mis   = s_addr[0];
            end
            3'b010: begin
                bad_w = 1'b0;
                mis   = |s_addr[1:0];
            end
            3'b100: bad_w = s_we;
            3'b101: begin
                bad_w = s_we;
                mis   = s_addr[0];
            end
            default: bad_w = 1'b1;
        endcase
    end

    assign rword = mem[idx];
    assign rbyte = 8'(rword >> {lane, 3'b000});
    assign rhalf = s_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_data = '0;
        case (s_width)
            3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
            3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
            3'b010:  ld_data = rword;
            3'b100:  ld_data = {24'h0, rbyte};
            3'b101:  ld_data = {16'h0, rhalf};
            default: ld_data = '0;
        endcase
    end

    assign rdata_nx = (err || s_we) ? 32'h0 : ld_data;

    always_comb begin
        be    = 4'b0000;
        wword = s_wdata;
        unique case (1'b1)
            (s_width[1:0] == 2'b00): begin
                be    = 4'b0001 << lane;
                wword = {4{s_wdata[7:0]}};
            end
            (s_width[1:0] == 2'b01): begin
                be    = s_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{s_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: if (accept) begin
                if (LATENCY == 1) begin
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
                end
            end
            WAIT: if (cnt == '0) state_nx = RESP;
                  else cnt_nx = cnt - CW'(1);
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_width <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_width <= req_width;
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_nx;
                rsp_err   <= err;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && s_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
            end
        end
    end

endmodule
